// File: rtl/mem_line_controller.sv
// Line memory initiator: arbitrates I-cache and D-cache line fills, performs an
// optional dirty-victim writeback before a D-cache fill, and models a fixed RAM access latency.
module mem_line_controller #(
    parameter int MEM_LATENCY = 5,
    parameter int ADDR_W      = 26,
    parameter int LINE_W      = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_line_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_fill_data,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_line_addr,
    input  logic              dc_wb_valid,
    input  logic [ADDR_W-1:0] dc_wb_addr,
    input  logic [LINE_W-1:0] dc_wb_data,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_fill_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [LINE_W-1:0] mem_rd_data,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [LINE_W-1:0] mem_wr_data,
    output logic              mem_wr_en,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_grant_dc;
    logic              r_grant_dc;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [LINE_W-1:0] r_wb_data;
    logic [LINE_W-1:0] r_ic_fill;
    logic [LINE_W-1:0] r_dc_fill;

    logic w_any_req;
    logic w_grant_dc;
    logic w_cnt_zero;
    logic w_start_wb;

    // On a tie the requester that was not served last wins.
    assign w_any_req  = ic_req | dc_req;
    assign w_grant_dc = dc_req & (~ic_req | ~r_last_grant_dc);
    assign w_start_wb = w_grant_dc & dc_wb_valid;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = w_start_wb ? S_WB : S_RD;
                end
            end
            S_WB: begin
                if (w_cnt_zero) begin
                    w_next_state = S_RD;
                end
            end
            S_RD: begin
                if (w_cnt_zero) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Transaction context is latched once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt           <= '0;
            r_last_grant_dc <= 1'b0;
            r_grant_dc      <= 1'b0;
            r_fill_addr     <= '0;
            r_wb_addr       <= '0;
            r_wb_data       <= '0;
            r_ic_fill       <= '0;
            r_dc_fill       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_dc  <= w_grant_dc;
                        r_fill_addr <= w_grant_dc ? dc_line_addr : ic_line_addr;
                        r_cnt       <= CNT_LOAD;
                        if (w_start_wb) begin
                            r_wb_addr <= dc_wb_addr;
                            r_wb_data <= dc_wb_data;
                        end
                    end
                end
                S_WB: begin
                    r_cnt <= w_cnt_zero ? CNT_LOAD : r_cnt - CNT_W'(1);
                end
                S_RD: begin
                    if (w_cnt_zero) begin
                        if (r_grant_dc) begin
                            r_dc_fill <= mem_rd_data;
                        end else begin
                            r_ic_fill <= mem_rd_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_last_grant_dc <= r_grant_dc;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // The write strobe fires only in the last WB cycle, so an aborted writeback never reaches RAM.
    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        ic_ready    = 1'b0;
        dc_ready    = 1'b0;
        case (r_state)
            S_WB: begin
                mem_wr_addr = r_wb_addr;
                mem_wr_data = r_wb_data;
                mem_wr_en   = w_cnt_zero;
            end
            S_RD: begin
                mem_rd_addr = r_fill_addr;
            end
            S_DONE: begin
                ic_ready = ~r_grant_dc;
                dc_ready = r_grant_dc;
            end
            default: begin
                mem_rd_addr = '0;
            end
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign ic_fill_data = r_ic_fill;
    assign dc_fill_data = r_dc_fill;

endmodule

// File: tb/tb_mem_line_controller.sv
// Directed bench for mem_line_controller: a latency-5 instance sharing a line RAM model,
// plus a latency-1 instance for back-to-back throughput.
module tb_mem_line_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         ic_req;
    logic [25:0]  ic_line_addr;
    logic         ic_ready;
    logic [127:0] ic_fill_data;
    logic         dc_req;
    logic [25:0]  dc_line_addr;
    logic         dc_wb_valid;
    logic [25:0]  dc_wb_addr;
    logic [127:0] dc_wb_data;
    logic         dc_ready;
    logic [127:0] dc_fill_data;
    logic [25:0]  mem_rd_addr;
    logic [127:0] mem_rd_data;
    logic [25:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic         mem_wr_en;
    logic         busy;

    logic         ic1_req;
    logic [25:0]  ic1_line_addr;
    logic         ic1_ready;
    logic [127:0] ic1_fill_data;
    logic         dc1_req;
    logic [25:0]  dc1_line_addr;
    logic         dc1_wb_valid;
    logic [25:0]  dc1_wb_addr;
    logic [127:0] dc1_wb_data;
    logic         dc1_ready;
    logic [127:0] dc1_fill_data;
    logic [25:0]  mem1_rd_addr;
    logic [127:0] mem1_rd_data;
    logic [25:0]  mem1_wr_addr;
    logic [127:0] mem1_wr_data;
    logic         mem1_wr_en;
    logic         busy1;

    mem_line_controller #(.MEM_LATENCY(5), .ADDR_W(26), .LINE_W(128)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_line_addr(ic_line_addr), .ic_ready(ic_ready), .ic_fill_data(ic_fill_data),
        .dc_req(dc_req), .dc_line_addr(dc_line_addr), .dc_wb_valid(dc_wb_valid),
        .dc_wb_addr(dc_wb_addr), .dc_wb_data(dc_wb_data), .dc_ready(dc_ready), .dc_fill_data(dc_fill_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .busy(busy)
    );

    mem_line_controller #(.MEM_LATENCY(1), .ADDR_W(26), .LINE_W(128)) dut1 (
        .clk(clk), .reset(reset),
        .ic_req(ic1_req), .ic_line_addr(ic1_line_addr), .ic_ready(ic1_ready), .ic_fill_data(ic1_fill_data),
        .dc_req(dc1_req), .dc_line_addr(dc1_line_addr), .dc_wb_valid(dc1_wb_valid),
        .dc_wb_addr(dc1_wb_addr), .dc_wb_data(dc1_wb_data), .dc_ready(dc1_ready), .dc_fill_data(dc1_fill_data),
        .mem_rd_addr(mem1_rd_addr), .mem_rd_data(mem1_rd_data), .mem_wr_addr(mem1_wr_addr),
        .mem_wr_data(mem1_wr_data), .mem_wr_en(mem1_wr_en), .busy(busy1)
    );

    // Line RAM: combinational read, write on the clock edge; preload port for the bench.
    logic [127:0] ram [0:4095];
    logic         pl_en;
    logic [11:0]  pl_addr;
    logic [127:0] pl_data;

    assign mem_rd_data  = ram[mem_rd_addr[11:0]];
    assign mem1_rd_data = ram[mem1_rd_addr[11:0]];

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr[11:0]] <= mem_wr_data;
        else if (pl_en) ram[pl_addr] <= pl_data;
    end

    int cyc = 0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] LINE0   = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE800 = 128'h00000003_00000002_00000001_00000000;
    localparam logic [127:0] WB_AA   = {4{32'hAAAAAAAA}};
    localparam logic [127:0] WB_12   = {8{16'h1234}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [127:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en   = 1'b0;
    endtask

    // Counts edges until the selected ready is seen; gives up after 40 edges.
    task automatic wait_rdy(input bit use_dc, input int start, output int n);
        n = start;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (use_dc ? dc_ready : ic_ready) break;
        end
    endtask

    int n;
    int wr0;
    int ct;

    initial begin
        reset = 1'b1;
        ic_req = 0; ic_line_addr = '0;
        dc_req = 0; dc_line_addr = '0; dc_wb_valid = 0; dc_wb_addr = '0; dc_wb_data = '0;
        ic1_req = 0; ic1_line_addr = '0;
        dc1_req = 0; dc1_line_addr = '0; dc1_wb_valid = 0; dc1_wb_addr = '0; dc1_wb_data = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;

        preload(12'h000, LINE0);
        preload(12'h800, LINE800);
        preload(12'h400, '0);
        preload(12'h010, '0);
        preload(12'h020, 128'h5);

        chk("rst_ctrl", 128'({ic_ready, dc_ready, mem_wr_en, busy}), '0);
        chk("rst_ic_fill", ic_fill_data, '0);
        chk("rst_dc_fill", dc_fill_data, '0);
        chk("rst_mem_addr", 128'({mem_rd_addr, mem_wr_addr}), '0);
        chk("rst_mem_wdata", mem_wr_data, '0);
        reset = 1'b0;
        step();

        // Plain I-cache fill of line 0.
        wr0 = wr_cnt;
        ic_req = 1; ic_line_addr = 26'h0;
        wait_rdy(1'b0, 0, n);
        chk("ic_lat", 128'(n), 128'(6));
        chk("ic_data", ic_fill_data, LINE0);
        chk("ic_busy_done", 128'({busy, dc_ready}), 128'(2'b10));
        ic_req = 0;
        step();
        chk("ic_idle_busy", 128'(busy), '0);
        chk("ic_no_wr", 128'(wr_cnt - wr0), '0);

        // D-cache fill of 0x800 with victim writeback to 0x400; inputs scrambled after accept.
        ct = cyc; wr0 = wr_cnt;
        dc_req = 1; dc_line_addr = 26'h800; dc_wb_valid = 1; dc_wb_addr = 26'h400; dc_wb_data = WB_AA;
        step();
        dc_line_addr = 26'h10; dc_wb_addr = 26'h11; dc_wb_data = '1;
        wait_rdy(1'b1, 1, n);
        chk("wb_lat", 128'(n), 128'(11));
        chk("wb_fill", dc_fill_data, LINE800);
        chk("wb_pulses", 128'(wr_cnt - wr0), 128'(1));
        chk("wb_pulse_cyc", 128'(wr_cyc - ct), 128'(5));
        chk("wb_ram", ram[12'h400], WB_AA);
        dc_req = 0; dc_wb_valid = 0;
        step();
        chk("idle_mem_out", 128'({mem_rd_addr, mem_wr_addr, mem_wr_en}), '0);
        chk("ic_fill_hold", ic_fill_data, LINE0);

        // Tie after reset goes to DC; DC re-requesting creates a second tie that goes to IC.
        reset = 1; step(); reset = 0;
        ic_req = 1; ic_line_addr = 26'h0;
        dc_req = 1; dc_line_addr = 26'h800;
        wait_rdy(1'b1, 0, n);
        chk("tie1_lat", 128'(n), 128'(6));
        chk("tie1_ic_quiet", 128'(ic_ready), '0);
        chk("tie1_data", dc_fill_data, LINE800);
        wait_rdy(1'b0, 0, n);
        chk("tie2_lat", 128'(n), 128'(7));
        chk("tie2_dc_quiet", 128'(dc_ready), '0);
        chk("tie2_data", ic_fill_data, LINE0);
        ic_req = 0;
        wait_rdy(1'b1, 0, n);
        chk("tie3_lat", 128'(n), 128'(7));
        dc_req = 0;
        step();

        // Writeback and fill to the same line: fill must return the written data.
        dc_req = 1; dc_line_addr = 26'h10; dc_wb_valid = 1; dc_wb_addr = 26'h10; dc_wb_data = WB_12;
        wait_rdy(1'b1, 0, n);
        chk("same_lat", 128'(n), 128'(11));
        chk("same_data", dc_fill_data, WB_12);
        dc_req = 0; dc_wb_valid = 0;
        step();

        // Reset during the third writeback cycle drops the transaction with no write.
        wr0 = wr_cnt;
        dc_req = 1; dc_line_addr = 26'h800; dc_wb_valid = 1; dc_wb_addr = 26'h20; dc_wb_data = '1;
        step(); step(); step();
        chk("abort_busy", 128'(busy), 128'(1));
        reset = 1;
        step();
        dc_req = 0; dc_wb_valid = 0;
        chk("abort_ctrl", 128'({ic_ready, dc_ready, mem_wr_en, busy}), '0);
        chk("abort_fills", 128'(ic_fill_data | dc_fill_data), '0);
        chk("abort_mem", 128'({mem_rd_addr, mem_wr_addr}) | mem_wr_data, '0);
        reset = 0;
        step(); step(); step(); step();
        chk("abort_no_wr", 128'(wr_cnt - wr0), '0);
        chk("abort_ram", ram[12'h020], 128'h5);
        ic_req = 1; ic_line_addr = 26'h800;
        wait_rdy(1'b0, 0, n);
        chk("post_lat", 128'(n), 128'(6));
        chk("post_data", ic_fill_data, LINE800);
        ic_req = 0;
        step();

        // Latency 1 with request held: ready every third cycle, one idle cycle between.
        ic1_req = 1; ic1_line_addr = 26'h0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("l1_ready_%0d", k), 128'(ic1_ready), 128'((k % 3) == 2));
            chk($sformatf("l1_busy_%0d", k), 128'(busy1), 128'((k % 3) != 0));
        end
        chk("l1_data", ic1_fill_data, LINE0);
        ic1_req = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
